deser_stream: RTL and testbench
===============================

Name: deser_stream

Overview:
- Parametrised successor to the team's fixed-width single-bit deserializer.
- Accepts LANES bits per beat and packs beats into WIDTH-bit words, either MSB-first or LSB-first.
- Supports early frame termination (partial words) and valid/ready back-pressure on both sides.
- Sits between serial/narrow PHY-side logic and word-wide datapath consumers.

Parameters:
- WIDTH, 16, output word width in bits; must be a multiple of LANES.
- LANES, 1, bits accepted per input beat (1..WIDTH).
- MSB_FIRST, 1, 1: first beat fills the most-significant end; 0: first beat fills the least-significant end.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- srst_i  input  1  reset; synchronous, active-high.
- data_i  input  LANES  input beat; data_i[LANES-1] is the earlier/more-significant bit when MSB_FIRST=1.
- data_val_i  input  1  beat valid.
- data_last_i  input  1  beat is the last of the frame; qualified by data_val_i.
- data_ready_o  output  1  block can accept a beat.
- deser_data_o  output  WIDTH  assembled word.
- deser_cnt_o  output  clog2(WIDTH+1)  number of valid bits in deser_data_o.
- deser_data_val_o  output  1  output word valid.
- deser_ready_i  input  1  downstream accepts the word.

Behaviour:
- Definitions:
  - BEATS = WIDTH/LANES.
  - Input beat accepted when data_val_i && data_ready_o.
  - Output transfer when deser_data_val_o && deser_ready_i.
- Storage:
  - Accumulator register, beat counter (0..BEATS-1), pending flag, output register.
- Beat placement, for beat index k (0-based):
  - MSB_FIRST=1: bits [WIDTH-1-k*LANES -: LANES].
  - MSB_FIRST=0: bits [k*LANES +: LANES], with data_i[0] in the lowest position.
- Word completes on an accepted beat when the counter is BEATS-1, or data_last_i=1.
  - Counter returns to 0 on completion.
  - data_last_i on a full-length final beat is a normal full word.
- Partial words:
  - Unfilled bit positions are 0.
  - deser_cnt_o = (beats accepted)*LANES.
  - A full word gives deser_cnt_o = WIDTH.
- Completion handling:
  - If the output register is empty, or a transfer occurs in the same cycle, the word loads into the output register. deser_data_val_o goes high on the next cycle (latency 1 cycle from the completing beat).
  - Back-to-back words with deser_ready_i held high produce no bubble.
  - Otherwise the word stays in the accumulator and the pending flag is set.
- data_ready_o = !pending (combinational).
  - While pending, no beats are accepted.
- Pending drain:
  - On an output transfer while pending, the pending word loads into the output register at that edge and pending clears.
  - data_ready_o rises the next cycle.
- Output stability:
  - While deser_data_val_o=1 and deser_ready_i=0, deser_data_o and deser_cnt_o hold stable.
  - deser_data_val_o stays high until the transfer.
- Input hold:
  - data_val_i=0 leaves the accumulator and counter unchanged; there is no timeout.
  - data_last_i is ignored when data_val_i=0.
- Reset (also mid-word or while pending):
  - Counter=0, pending=0, accumulator=0.
  - deser_data_o=0, deser_cnt_o=0, deser_data_val_o=0.
  - data_ready_o=1 in the first cycle after reset.
  - Partial and pending words are discarded.
- deser_data_val_o is registered.
- data_ready_o depends only on registered state (no combinational path from deser_ready_i).

Test Plan:
- Full word, MSB-first (WIDTH=16, LANES=4, MSB_FIRST=1, deser_ready_i=1): beats 4'hA, 4'hB, 4'hC, 4'hD on consecutive cycles -> deser_data_o=16'hABCD, deser_cnt_o=16, deser_data_val_o high exactly one cycle, one cycle after the 4th beat.
- Full word, LSB-first (MSB_FIRST=0): same beats -> 16'hDCBA, deser_cnt_o=16.
- Partial word, single-bit lanes (LANES=1, MSB_FIRST=1): bits 1, 0, 1 with data_last_i on the 3rd -> 16'hA000, deser_cnt_o=3. The next frame starts at beat index 0.
- Back-pressure (LANES=4): deser_ready_i=0, send 16'h1234 then 16'h5678 ->
  - first word held stable at the output;
  - data_ready_o low from the cycle after the 8th beat;
  - raise deser_ready_i -> 16'h1234 transfers, 16'h5678 valid the next cycle, data_ready_o high again.
- Back-to-back streaming: 3 words with deser_ready_i=1 and data_val_i continuously high -> data_ready_o never drops, three valid pulses spaced BEATS cycles apart.
- Reset: srst_i asserted after 2 of 4 beats, and separately while a word is pending -> all outputs 0 and data_ready_o=1 after reset. The next 4 beats yield a clean word with no residue from the discarded data.

Source files
------------

// File: rtl/deser_stream.sv
// deser_stream: packs LANES-bit input beats into WIDTH-bit words.
// Frames may end early, which yields a partial word. Both sides use
// valid/ready handshakes.
//
// Parameters:
//   WIDTH      output word width; must be a multiple of LANES
//   LANES      bits per input beat (1..WIDTH)
//   MSB_FIRST  1: first beat lands at the MSB end; 0: first beat lands at the LSB end
//
// Ports:
//   clk_i             clock; all logic on the rising edge
//   srst_i            synchronous active-high reset
//   data_i            input beat
//   data_val_i        beat valid
//   data_last_i       last beat of the frame (qualified by data_val_i)
//   data_ready_o      block can accept a beat (registered state only)
//   deser_data_o      assembled word; unfilled positions are zero
//   deser_cnt_o       number of valid bits in deser_data_o
//   deser_data_val_o  output word valid (registered)
//   deser_ready_i     downstream accepts the word
module deser_stream #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned LANES     = 1,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic                           clk_i,
  input  logic                           srst_i,
  input  logic [LANES-1:0]               data_i,
  input  logic                           data_val_i,
  input  logic                           data_last_i,
  output logic                           data_ready_o,
  output logic [WIDTH-1:0]               deser_data_o,
  output logic [$clog2(WIDTH+1)-1:0]     deser_cnt_o,
  output logic                           deser_data_val_o,
  input  logic                           deser_ready_i
);

  localparam int unsigned Beats = WIDTH / LANES;
  localparam int unsigned CntW  = $clog2(WIDTH + 1);
  localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic             pend_q, pend_d;
  logic [CntW-1:0]  pend_cnt_q, pend_cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CntW-1:0]  out_cnt_q, out_cnt_d;
  logic             out_val_q, out_val_d;

  logic             beat_fire;
  logic             out_fire;
  logic             word_done;
  logic             load_ok;
  logic [WIDTH-1:0] beat_word;
  logic [WIDTH-1:0] acc_new;
  logic [CntW-1:0]  cnt_new;

  assign data_ready_o     = ~pend_q;
  assign deser_data_o     = out_q;
  assign deser_cnt_o      = out_cnt_q;
  assign deser_data_val_o = out_val_q;

  assign beat_fire = data_val_i & ~pend_q;
  assign out_fire  = out_val_q & deser_ready_i;
  assign word_done = beat_fire & ((beat_q == LastBeat) | data_last_i);
  // The output register can take a new word if it is empty or is being drained this cycle.
  assign load_ok   = ~out_val_q | out_fire;

  // Unfilled positions of acc_q are always zero, so OR-ing in the shifted beat is enough.
  always_comb begin
    beat_word = '0;
    if (MSB_FIRST != 0) begin
      beat_word = (WIDTH'(data_i) << (WIDTH - LANES)) >> (32'(beat_q) * LANES);
    end else begin
      beat_word = WIDTH'(data_i) << (32'(beat_q) * LANES);
    end
  end

  assign acc_new = acc_q | beat_word;
  assign cnt_new = CntW'((32'(beat_q) + 32'd1) * LANES);

  always_comb begin
    acc_d      = acc_q;
    beat_d     = beat_q;
    pend_d     = pend_q;
    pend_cnt_d = pend_cnt_q;
    out_d      = out_q;
    out_cnt_d  = out_cnt_q;
    out_val_d  = out_val_q;

    if (out_fire) begin
      out_val_d = 1'b0;
    end

    // A pending word is parked in the accumulator; move it out as soon as the output drains.
    if (pend_q && out_fire) begin
      out_d     = acc_q;
      out_cnt_d = pend_cnt_q;
      out_val_d = 1'b1;
      pend_d    = 1'b0;
      acc_d     = '0;
    end

    // beat_fire implies !pend_q, so this never collides with the drain above.
    if (beat_fire) begin
      if (word_done) begin
        beat_d = '0;
        if (load_ok) begin
          out_d     = acc_new;
          out_cnt_d = cnt_new;
          out_val_d = 1'b1;
          acc_d     = '0;
        end else begin
          acc_d      = acc_new;
          pend_d     = 1'b1;
          pend_cnt_d = cnt_new;
        end
      end else begin
        acc_d  = acc_new;
        beat_d = beat_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      acc_q      <= '0;
      beat_q     <= '0;
      pend_q     <= 1'b0;
      pend_cnt_q <= '0;
      out_q      <= '0;
      out_cnt_q  <= '0;
      out_val_q  <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      beat_q     <= beat_d;
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
      out_q      <= out_d;
      out_cnt_q  <= out_cnt_d;
      out_val_q  <= out_val_d;
    end
  end

endmodule

// File: tb/tb_deser_stream.sv
// Bench for deser_stream.
// Two 4-lane instances (MSB-first and LSB-first) share one stimulus stream.
// A 1-lane MSB-first instance has its own stimulus.
// Expected words are queued at issue time and popped by a monitor on each output transfer.
module tb_deser_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic srst;

  // Shared 4-lane stimulus.
  logic [3:0]  d4;
  logic        v4, l4, r4;
  logic        m_rdy, m_vo, l_rdy, l_vo;
  logic [15:0] m_out, l_out;
  logic [4:0]  m_cnt, l_cnt;

  // 1-lane stimulus.
  logic        b_d, b_v, b_l, b_ri, b_rdy, b_vo;
  logic [15:0] b_out;
  logic [4:0]  b_cnt;

  deser_stream #(.WIDTH(16), .LANES(4), .MSB_FIRST(1)) u_msb (
    .clk_i(clk), .srst_i(srst), .data_i(d4), .data_val_i(v4), .data_last_i(l4),
    .data_ready_o(m_rdy), .deser_data_o(m_out), .deser_cnt_o(m_cnt),
    .deser_data_val_o(m_vo), .deser_ready_i(r4)
  );

  deser_stream #(.WIDTH(16), .LANES(4), .MSB_FIRST(0)) u_lsb (
    .clk_i(clk), .srst_i(srst), .data_i(d4), .data_val_i(v4), .data_last_i(l4),
    .data_ready_o(l_rdy), .deser_data_o(l_out), .deser_cnt_o(l_cnt),
    .deser_data_val_o(l_vo), .deser_ready_i(r4)
  );

  deser_stream #(.WIDTH(16), .LANES(1), .MSB_FIRST(1)) u_bit (
    .clk_i(clk), .srst_i(srst), .data_i(b_d), .data_val_i(b_v), .data_last_i(b_l),
    .data_ready_o(b_rdy), .deser_data_o(b_out), .deser_cnt_o(b_cnt),
    .deser_data_val_o(b_vo), .deser_ready_i(b_ri)
  );

  typedef struct packed {
    logic [15:0] data;
    logic [4:0]  cnt;
  } exp_t;

  exp_t qm[$], ql[$], qb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   tq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard monitor: sample mid-cycle, pop one expectation per output transfer.
  exp_t e;
  always @(negedge clk) begin
    if (!srst && m_vo && r4) begin
      if (qm.size() == 0) chk("msb unexpected word", 32'(qm.size()), 32'd1);
      else begin
        e = qm.pop_front();
        chk("msb data", 32'(m_out), 32'(e.data));
        chk("msb cnt", 32'(m_cnt), 32'(e.cnt));
      end
      tq.push_back(cyc);
    end
    if (!srst && l_vo && r4) begin
      if (ql.size() == 0) chk("lsb unexpected word", 32'(ql.size()), 32'd1);
      else begin
        e = ql.pop_front();
        chk("lsb data", 32'(l_out), 32'(e.data));
        chk("lsb cnt", 32'(l_cnt), 32'(e.cnt));
      end
    end
    if (!srst && b_vo && b_ri) begin
      if (qb.size() == 0) chk("bit unexpected word", 32'(qb.size()), 32'd1);
      else begin
        e = qb.pop_front();
        chk("bit data", 32'(b_out), 32'(e.data));
        chk("bit cnt", 32'(b_cnt), 32'(e.cnt));
      end
    end
  end

  // Drive one 4-lane beat and hold it until accepted; returns the number of stall cycles.
  task automatic beat4(input logic [3:0] d, input logic last, output int stalls);
    logic acc;
    d4 = d; v4 = 1'b1; l4 = last; stalls = 0; acc = 1'b0;
    while (!acc) begin
      @(negedge clk);
      acc = m_rdy;
      @(posedge clk); #1;
      if (!acc) begin
        stalls++;
        if (stalls > 200) begin
          $display("FAIL beat4 timeout: got stalled %0d cycles expected acceptance", stalls);
          $fatal(1, "beat timeout");
        end
      end
    end
  endtask

  // nib holds the beats in issue order, first beat in the top nibble.
  task automatic send4(input logic [15:0] nib, input int k, input logic last_final,
                       input logic [15:0] em, input logic [15:0] el, output int stalls);
    int s;
    qm.push_back('{data: em, cnt: 5'(4 * k)});
    ql.push_back('{data: el, cnt: 5'(4 * k)});
    stalls = 0;
    for (int i = 0; i < k; i++) begin
      beat4(nib[15-4*i -: 4], (i == k - 1) ? last_final : 1'b0, s);
      stalls += s;
    end
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n, input logic [15:0] exp);
    logic acc;
    int   st;
    qb.push_back('{data: exp, cnt: 5'(n)});
    for (int i = 0; i < n; i++) begin
      b_d = bits[15-i]; b_v = 1'b1; b_l = (i == n - 1);
      acc = 1'b0; st = 0;
      while (!acc) begin
        @(negedge clk);
        acc = b_rdy;
        @(posedge clk); #1;
        if (!acc) begin
          st++;
          if (st > 200) begin
            $display("FAIL bit beat timeout: got stalled %0d cycles expected acceptance", st);
            $fatal(1, "bit beat timeout");
          end
        end
      end
    end
    b_v = 1'b0; b_l = 1'b0;
  endtask

  task automatic idle4();
    v4 = 1'b0; l4 = 1'b0;
  endtask

  task automatic do_reset();
    srst = 1'b1; v4 = 1'b0; l4 = 1'b0; b_v = 1'b0; b_l = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    qm.delete(); ql.delete(); qb.delete();
    srst = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " msb data"}, 32'(m_out), 32'h0);
    chk({tag, " msb cnt"}, 32'(m_cnt), 32'h0);
    chk({tag, " msb val"}, 32'(m_vo), 32'h0);
    chk({tag, " msb ready"}, 32'(m_rdy), 32'h1);
    chk({tag, " lsb val"}, 32'(l_vo), 32'h0);
    chk({tag, " lsb ready"}, 32'(l_rdy), 32'h1);
    chk({tag, " bit val"}, 32'(b_vo), 32'h0);
    chk({tag, " bit ready"}, 32'(b_rdy), 32'h1);
  endtask

  initial begin
    int s, st;
    srst = 1'b1; d4 = '0; v4 = 1'b0; l4 = 1'b0; r4 = 1'b1;
    b_d = 1'b0; b_v = 1'b0; b_l = 1'b0; b_ri = 1'b1;
    do_reset();
    check_reset("initial");

    // Full word: valid exactly one cycle, in the cycle after the 4th beat.
    send4(16'hABCD, 4, 1'b0, 16'hABCD, 16'hDCBA, s);
    chk("full val after last beat", 32'(m_vo), 32'h1);
    chk("full lsb val after last beat", 32'(l_vo), 32'h1);
    idle4();
    @(posedge clk); #1;
    chk("full val one cycle", 32'(m_vo), 32'h0);

    // Partial 4-lane word of two beats.
    send4(16'h7E00, 2, 1'b1, 16'h7E00, 16'h00E7, s);
    idle4();
    repeat (2) @(posedge clk);
    #1;

    // Single-bit lanes: partial frame, then a full frame restarting at beat 0.
    send_bits(16'hA000, 3, 16'hA000);
    send_bits(16'hC3A5, 16, 16'hC3A5);
    repeat (2) @(posedge clk);
    #1;

    // Back-pressure: second word goes pending.
    r4 = 1'b0;
    send4(16'h1234, 4, 1'b0, 16'h1234, 16'h4321, s);
    send4(16'h5678, 4, 1'b0, 16'h5678, 16'h8765, s);
    idle4();
    chk("bp ready low", 32'(m_rdy), 32'h0);
    chk("bp held data", 32'(m_out), 32'h1234);
    chk("bp held cnt", 32'(m_cnt), 32'd16);
    repeat (3) @(posedge clk);
    #1;
    chk("bp stable data", 32'(m_out), 32'h1234);
    chk("bp stable val", 32'(m_vo), 32'h1);
    chk("bp stable lsb data", 32'(l_out), 32'h4321);
    r4 = 1'b1;
    @(posedge clk); #1;
    chk("bp drain data", 32'(m_out), 32'h5678);
    chk("bp drain val", 32'(m_vo), 32'h1);
    chk("bp ready back", 32'(m_rdy), 32'h1);
    @(posedge clk); #1;
    chk("bp done val", 32'(m_vo), 32'h0);

    // Back-to-back streaming; last on a full-length final beat is a normal word.
    tq.delete();
    st = 0;
    send4(16'h9E37, 4, 1'b0, 16'h9E37, 16'h73E9, s); st += s;
    send4(16'h79B9, 4, 1'b1, 16'h79B9, 16'h9B97, s); st += s;
    send4(16'h7F4A, 4, 1'b0, 16'h7F4A, 16'hA4F7, s); st += s;
    idle4();
    repeat (3) @(posedge clk);
    #1;
    chk("stream stalls", 32'(st), 32'd0);
    chk("stream pulses", 32'(tq.size()), 32'd3);
    if (tq.size() == 3) begin
      chk("stream spacing 1", 32'(tq[1] - tq[0]), 32'd4);
      chk("stream spacing 2", 32'(tq[2] - tq[1]), 32'd4);
    end

    // Reset mid-word: the two discarded beats must leave no residue.
    beat4(4'hF, 1'b0, s);
    beat4(4'hF, 1'b0, s);
    do_reset();
    check_reset("reset midword");
    send4(16'h1234, 4, 1'b0, 16'h1234, 16'h4321, s);
    idle4();
    repeat (2) @(posedge clk);
    #1;

    // Reset while a word is pending.
    r4 = 1'b0;
    send4(16'hAAAA, 4, 1'b0, 16'hAAAA, 16'hAAAA, s);
    send4(16'h5555, 4, 1'b0, 16'h5555, 16'h5555, s);
    idle4();
    chk("pending before reset", 32'(m_rdy), 32'h0);
    do_reset();
    check_reset("reset pending");
    r4 = 1'b1;
    send4(16'h1E2D, 4, 1'b0, 16'h1E2D, 16'hD2E1, s);
    idle4();

    for (int i = 0; i < 50; i++) begin
      if (qm.size() == 0 && ql.size() == 0 && qb.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("msb queue drained", 32'(qm.size()), 32'd0);
    chk("lsb queue drained", 32'(ql.size()), 32'd0);
    chk("bit queue drained", 32'(qb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
